// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer between the multicycle datapath and word-wide memory.
// Handles alignment checks, load extraction/extension and read-modify-write for SH/SB.
module mem_access_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ready,
  output logic        Done,
  output logic        AddrErr,
  output logic [31:0] RData,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DONE,
    ERR
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic [2:0]     opReg;
  logic [1:0]     offReg;
  logic [15:0]    wdataReg;
  logic [31:0]    wordReg;
  logic [CW-1:0]  latCnt;

  logic           misaligned;
  logic           lastRead;
  logic           opIsLoad;
  logic [7:0]     loadByte;
  logic [15:0]    loadHalf;
  logic [31:0]    loadExt;
  logic [31:0]    mergedWord;

  always_comb begin
    misaligned = 1'b0;
    case (Op)
      OP_LW, OP_SW:         misaligned = |Addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = Addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign lastRead = (latCnt == CW'(MEM_LAT - 1));
  assign opIsLoad = (opReg <= OP_LBU);

  // Lane extraction works on the live memory word so RData lands on the capture edge.
  always_comb begin
    loadByte = MemRData[{offReg, 3'b000} +: 8];
    loadHalf = offReg[1] ? MemRData[31:16] : MemRData[15:0];
    loadExt  = MemRData;
    case (opReg)
      OP_LH:   loadExt = {{16{loadHalf[15]}}, loadHalf};
      OP_LHU:  loadExt = {16'h0000, loadHalf};
      OP_LB:   loadExt = {{24{loadByte[7]}}, loadByte};
      OP_LBU:  loadExt = {24'h000000, loadByte};
      default: loadExt = MemRData;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic       laneSel;
    logic [7:0] laneData;
    assign laneSel  = (opReg == OP_SB) ? (offReg == 2'(gi)) : (offReg[1] == 1'(gi / 2));
    assign laneData = (opReg == OP_SB) ? wdataReg[7:0] : wdataReg[8*(gi%2) +: 8];
    assign mergedWord[8*gi +: 8] = laneSel ? laneData : wordReg[8*gi +: 8];
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (misaligned)        stateNext = ERR;
          else if (Op == OP_SW)  stateNext = WRITE;
          else                   stateNext = READ;
        end
      end
      READ:    if (lastRead) stateNext = opIsLoad ? DONE : MERGE;
      MERGE:   stateNext = WRITE;
      WRITE:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign Ready   = (state == IDLE);
  assign Done    = (state == DONE);
  assign AddrErr = (state == ERR);
  assign MemWr   = (state == WRITE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      opReg    <= OP_LW;
      offReg   <= 2'b00;
      wdataReg <= 16'h0000;
      wordReg  <= 32'h0;
      latCnt   <= '0;
      RData    <= 32'h0;
      MemAddr  <= 32'h0;
      MemWData <= 32'h0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (Req) begin
            opReg    <= Op;
            offReg   <= Addr[1:0];
            wdataReg <= WData[15:0];
            MemAddr  <= {Addr[31:2], 2'b00};
            latCnt   <= '0;
            if (Op == OP_SW && !misaligned) MemWData <= WData;
          end
        end
        READ: begin
          if (lastRead) begin
            wordReg <= MemRData;
            if (opIsLoad) RData <= loadExt;
          end else begin
            latCnt <= latCnt + 1'b1;
          end
        end
        MERGE:   MemWData <= mergedWord;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word memory model plus a byte-level reference model.
module tb_mem_access_unit;
  localparam int LAT = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Ready;
  logic        Done;
  logic        AddrErr;
  logic [31:0] RData;
  logic [31:0] MemAddr;
  logic        MemWr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;

  int total = 0;
  int bad = 0;

  logic [31:0] tbMem [64];
  logic [7:0]  refMem [256];
  logic [31:0] refRData;

  int          lat, dn, er, wr, both;
  logic [31:0] ma;
  bit          rdy;

  mem_access_unit #(.MEM_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WData(WData),
    .Ready(Ready), .Done(Done), .AddrErr(AddrErr), .RData(RData),
    .MemAddr(MemAddr), .MemWr(MemWr), .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  assign MemRData = tbMem[MemAddr[7:2]];
  always @(posedge Clk) if (MemWr) tbMem[MemAddr[7:2]] <= MemWData;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] refWord(input int idx);
    return {refMem[idx*4+3], refMem[idx*4+2], refMem[idx*4+1], refMem[idx*4]};
  endfunction

  function automatic bit refMis(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd0, 3'd5:       return (a % 4) != 0;
      3'd1, 3'd2, 3'd6: return (a % 2) != 0;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] a);
    int b = int'(a & 32'hFF);
    int h, v;
    case (op)
      3'd0: return refWord(b / 4);
      3'd1, 3'd2: begin
        h = int'(refMem[b+1]) * 256 + int'(refMem[b]);
        if (op == 3'd1 && h >= 32768) return 32'(h - 65536);
        return 32'(h);
      end
      default: begin
        v = int'(refMem[b]);
        if (op == 3'd3 && v >= 128) return 32'(v - 256);
        return 32'(v);
      end
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] op, input bit mis);
    if (mis) return 1;
    case (op)
      3'd5:       return 2;
      3'd6, 3'd7: return LAT + 3;
      default:    return LAT + 1;
    endcase
  endfunction

  task automatic applyStore(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int b = int'(a & 32'hFF);
    int n = (op == 3'd5) ? 4 : (op == 3'd6) ? 2 : 1;
    for (int k = 0; k < n; k++) refMem[b+k] = 8'((wd >> (8*k)) & 32'hFF);
  endtask

  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    if (!refMis(op, a)) begin
      if (op <= 3'd4) refRData = refLoad(op, a);
      else applyStore(op, a, wd);
    end
  endtask

  // Issues one request and records what the DUT did until it is ready again.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input bit holdReq);
    @(negedge Clk);
    rdy = Ready;
    Req = 1'b1; Op = op; Addr = a; WData = wd;
    lat = -1; dn = 0; er = 0; wr = 0; both = 0; ma = 32'h0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        ma = MemAddr;
        if (holdReq) begin
          Op = 3'd0; Addr = 32'h44;
        end else begin
          Req = 1'b0; Op = 3'($urandom); Addr = $urandom; WData = $urandom;
        end
      end
      if (MemWr) wr++;
      if (Done) dn++;
      if (AddrErr) er++;
      if (Done && AddrErr) both++;
      if ((Done || AddrErr) && lat < 0) lat = n;
      if (Ready) break;
    end
    Req = 1'b0;
    $display("txn op=%0d addr=%h wdata=%h lat=%0d done=%0d err=%0d wr=%0d rdata=%h",
             op, a, wd, lat, dn, er, wr, RData);
  endtask

  task automatic test_reset;
    Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = 32'h0; WData = 32'h0;
    repeat (3) @(negedge Clk);
    if (Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", Ready); end
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
    total++;
    if (AddrErr !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", AddrErr); end
    total++;
    if (RData !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", RData); end
    total++;
    if (MemAddr !== 32'h0) begin bad++; $display("FAIL reset_memaddr: got %h want 0", MemAddr); end
    total++;
    if (MemWr !== 1'b0) begin bad++; $display("FAIL reset_memwr: got %b want 0", MemWr); end
    total++;
    if (MemWData !== 32'h0) begin bad++; $display("FAIL reset_memwdata: got %h want 0", MemWData); end
    total++;
    Reset = 1'b0;
    refRData = 32'h0;
  endtask

  task automatic test_loads;
    logic [2:0]  ops  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
    logic [31:0] adrs [5] = '{32'h42, 32'h42, 32'h42, 32'h40, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    for (int i = 0; i < 5; i++) begin
      runOp(ops[i], adrs[i], $urandom, 1'b0);
      modelOp(ops[i], adrs[i], 32'h0);
      if (RData !== exps[i]) begin bad++; $display("FAIL load_rdata[%0d]: got %h want %h", i, RData, exps[i]); end
      total++;
      if (lat != LAT + 1) begin bad++; $display("FAIL load_lat[%0d]: got %0d want %0d", i, lat, LAT + 1); end
      total++;
      if (wr != 0 || dn != 1 || er != 0) begin
        bad++; $display("FAIL load_pulses[%0d]: got wr=%0d done=%0d err=%0d want 0/1/0", i, wr, dn, er);
      end
      total++;
      if (ma !== 32'h40) begin bad++; $display("FAIL load_memaddr[%0d]: got %h want 00000040", i, ma); end
      total++;
    end
  endtask

  task automatic test_store_byte;
    runOp(3'd7, 32'h41, 32'h123456EE, 1'b0);
    modelOp(3'd7, 32'h41, 32'h123456EE);
    if (tbMem[16] !== 32'h8899EEBB) begin bad++; $display("FAIL sb_mem: got %h want 8899eebb", tbMem[16]); end
    total++;
    if (wr != 1) begin bad++; $display("FAIL sb_wrcount: got %0d want 1", wr); end
    total++;
    if (lat != LAT + 3) begin bad++; $display("FAIL sb_lat: got %0d want %0d", lat, LAT + 3); end
    total++;
    if (RData !== 32'h8899AABB) begin bad++; $display("FAIL sb_rdata_held: got %h want 8899aabb", RData); end
    total++;
  endtask

  task automatic test_misaligned;
    logic [2:0]  ops  [2] = '{3'd6, 3'd5};
    logic [31:0] adrs [2] = '{32'h41, 32'h42};
    for (int i = 0; i < 2; i++) begin
      runOp(ops[i], adrs[i], 32'hDEADBEEF, 1'b0);
      if (lat != 1 || er != 1 || dn != 0) begin
        bad++; $display("FAIL mis_pulse[%0d]: got lat=%0d err=%0d done=%0d want 1/1/0", i, lat, er, dn);
      end
      total++;
      if (wr != 0) begin bad++; $display("FAIL mis_memwr[%0d]: got %0d want 0", i, wr); end
      total++;
      if (tbMem[16] !== 32'h8899EEBB) begin bad++; $display("FAIL mis_mem[%0d]: got %h want 8899eebb", i, tbMem[16]); end
      total++;
      if (RData !== refRData) begin bad++; $display("FAIL mis_rdata[%0d]: got %h want %h", i, RData, refRData); end
      total++;
    end
  endtask

  task automatic test_reset_merge;
    int wrSeen = 0;
    @(negedge Clk);
    Req = 1'b1; Op = 3'd6; Addr = 32'h42; WData = 32'h0000CAFE;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge Clk);
      if (n == 1) Req = 1'b0;
      if (MemWr) wrSeen++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    if (MemWr) wrSeen++;
    if (Ready !== 1'b1) begin bad++; $display("FAIL rstmerge_ready: got %b want 1", Ready); end
    total++;
    Reset = 1'b0;
    refRData = 32'h0;
    repeat (4) begin
      @(negedge Clk);
      if (MemWr) wrSeen++;
    end
    $display("txn op=6 addr=00000042 reset-in-merge wr=%0d", wrSeen);
    if (wrSeen != 0) begin bad++; $display("FAIL rstmerge_memwr: got %0d want 0", wrSeen); end
    total++;
    if (tbMem[16] !== refWord(16)) begin bad++; $display("FAIL rstmerge_mem: got %h want %h", tbMem[16], refWord(16)); end
    total++;
    if (RData !== 32'h0) begin bad++; $display("FAIL rstmerge_rdata: got %h want 0", RData); end
    total++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] wd = $urandom;
    logic [31:0] w17 = refWord(17);
    runOp(3'd7, 32'h43, wd, 1'b1);
    modelOp(3'd7, 32'h43, wd);
    if (dn != 1 || er != 0 || lat != LAT + 3) begin
      bad++; $display("FAIL busy_done: got done=%0d err=%0d lat=%0d want 1/0/%0d", dn, er, lat, LAT + 3);
    end
    total++;
    @(negedge Clk);
    if (Done !== 1'b0 || MemWr !== 1'b0) begin
      bad++; $display("FAIL busy_after: got done=%b memwr=%b want 0/0", Done, MemWr);
    end
    total++;
    if (tbMem[16] !== refWord(16)) begin bad++; $display("FAIL busy_mem: got %h want %h", tbMem[16], refWord(16)); end
    total++;
    if (RData !== refRData || tbMem[17] !== w17) begin
      bad++; $display("FAIL busy_ignored: got rdata=%h m17=%h want %h/%h", RData, tbMem[17], refRData, w17);
    end
    total++;
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, wd;
    bit          mis;
    int          idx;
    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 255));
      wd  = $urandom;
      mis = refMis(op, a);
      idx = int'((a & 32'hFF) / 4);
      runOp(op, a, wd, 1'b0);
      modelOp(op, a, wd);
      if (lat != expLat(op, mis)) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, expLat(op, mis)); end
      total++;
      if (dn + er != 1 || er != int'(mis) || both != 0) begin
        bad++; $display("FAIL rnd_pulse[%0d]: got done=%0d err=%0d both=%0d want err=%0d", i, dn, er, both, mis);
      end
      total++;
      if (wr != int'(!mis && op >= 3'd5)) begin bad++; $display("FAIL rnd_wr[%0d]: got %0d want %0d", i, wr, int'(!mis && op >= 3'd5)); end
      total++;
      if (RData !== refRData) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, RData, refRData); end
      total++;
      if (tbMem[idx] !== refWord(idx)) begin bad++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, tbMem[idx], refWord(idx)); end
      total++;
      if (!rdy) begin bad++; $display("FAIL rnd_ready[%0d]: got 0 want 1", i); end
      total++;
      if (!mis && ma !== (a & 32'hFFFFFFFC)) begin bad++; $display("FAIL rnd_memaddr[%0d]: got %h want %h", i, ma, a & 32'hFFFFFFFC); end
      if (!mis) total++;
    end
  endtask

  initial begin
    logic [31:0] w;
    Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = 32'h0; WData = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w = (i == 16) ? 32'h8899AABB : $urandom;
      tbMem[i] <= w;
      for (int k = 0; k < 4; k++) refMem[i*4+k] = 8'((w >> (8*k)) & 32'hFF);
    end
    test_reset;
    test_loads;
    test_store_byte;
    test_misaligned;
    test_reset_merge;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
